// File: rtl/data_mem_pkg.sv
// Shared types for the byte-addressed data memory.
// Size codes, FSM states, latched request and fault check.
package data_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic        write;
    logic        both;
  } req_t;

  function automatic logic access_fault(
    input logic [31:0] addr,
    input logic [1:0]  size,
    input logic        both,
    input logic [31:0] depth
  );
    logic [31:0] idx;
    idx = {2'b00, addr[31:2]};
    access_fault = both
      | (size == 2'b11)
      | ((size == SZ_HALF) && addr[0])
      | ((size == SZ_WORD) && (addr[1:0] != 2'b00))
      | (idx >= depth);
  endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Load/store request bus between the pipeline and data memory.
// Master drives the request, slave returns data and status.
interface data_memory_ctrl_if;

  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] Write_Data;
  logic [1:0]  Size;
  logic        Unsigned;
  logic [31:0] Read_Data;
  logic        Ready;
  logic        Fault;
  logic        Busy;

  modport master (
    output MemRead, MemWrite, Address,
    output Write_Data, Size, Unsigned,
    input  Read_Data, Ready, Fault, Busy
  );

  modport slave (
    input  MemRead, MemWrite, Address,
    input  Write_Data, Size, Unsigned,
    output Read_Data, Ready, Fault, Busy
  );

endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane steering for sub-word stores and loads.
// Stores merge into the old word; loads extract and extend.
import data_mem_pkg::*;

module mem_lane_align (
  input  logic [31:0] old_word,
  input  logic [31:0] store_data,
  input  logic [1:0]  byte_sel,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  logic [4:0]  b_off;
  logic [4:0]  h_off;
  logic [7:0]  b_val;
  logic [15:0] h_val;

  assign b_off = {byte_sel, 3'b000};
  assign h_off = {byte_sel[1], 4'b0000};
  assign b_val = old_word[b_off +: 8];
  assign h_val = old_word[h_off +: 16];

  // Replace only the addressed lanes of the old word
  always_comb begin
    merged = old_word;
    case (size)
      SZ_BYTE: merged[b_off +: 8]  = store_data[7:0];
      SZ_HALF: merged[h_off +: 16] = store_data[15:0];
      SZ_WORD: merged              = store_data;
      default: merged              = old_word;
    endcase
  end

  // Pick the addressed lane and zero/sign extend it
  always_comb begin
    load_data = old_word;
    case (size)
      SZ_BYTE:
        load_data = uns ? {24'd0, b_val}
                        : {{24{b_val[7]}}, b_val};
      SZ_HALF:
        load_data = uns ? {16'd0, h_val}
                        : {{16{h_val[15]}}, h_val};
      default:
        load_data = old_word;
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Clocked byte-addressed data memory with wait states,
// fault reporting and zero-fill after reset.
import data_mem_pkg::*;

module data_memory_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 0
) (
  input logic clk,
  input logic rst,
  data_memory_ctrl_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] WS_LOAD =
    (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  logic [31:0]   mem [DEPTH_WORDS];
  state_t        state;
  logic [AW-1:0] init_cnt;
  logic [2:0]    wait_cnt;
  req_t          req;

  logic [AW-1:0] widx;
  logic [31:0]   old_word;
  logic [31:0]   merged;
  logic [31:0]   load_data;
  logic          req_fault;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;

  assign widx      = req.addr[AW+1:2];
  assign old_word  = mem[widx];
  assign req_fault = access_fault(req.addr, req.size,
                                  req.both, 32'(DEPTH_WORDS));

  mem_lane_align u_align (
    .old_word   (old_word),
    .store_data (req.wdata),
    .byte_sel   (req.addr[1:0]),
    .size       (req.size),
    .uns        (req.uns),
    .merged     (merged),
    .load_data  (load_data)
  );

  // Single write port: zero-fill during INIT, store in DONE
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = widx;
    mem_wdata = merged;
    if (!rst && state == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = init_cnt;
      mem_wdata = 32'd0;
    end else if (!rst && state == ST_DONE
                 && req.write && !req_fault) begin
      mem_we = 1'b1;
    end
  end

  // Storage array
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_waddr] <= mem_wdata;
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_INIT;
      init_cnt      <= '0;
      wait_cnt      <= 3'd0;
      req           <= '0;
      bus.Read_Data <= 32'd0;
      bus.Ready     <= 1'b0;
      bus.Fault     <= 1'b0;
      bus.Busy      <= 1'b1;
    end else begin
      bus.Ready <= 1'b0;
      bus.Fault <= 1'b0;
      case (state)
        ST_INIT: begin
          if (init_cnt == LAST_IDX) begin
            state    <= ST_IDLE;
            bus.Busy <= 1'b0;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          bus.Busy <= bus.MemRead | bus.MemWrite;
          if (bus.MemRead | bus.MemWrite) begin
            req <= '{
              addr:  bus.Address,
              wdata: bus.Write_Data,
              size:  bus.Size,
              uns:   bus.Unsigned,
              write: bus.MemWrite & ~bus.MemRead,
              both:  bus.MemWrite & bus.MemRead
            };
            if (WAIT_STATES > 0) begin
              state    <= ST_WAIT;
              wait_cnt <= WS_LOAD;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 3'd0)
            state <= ST_DONE;
          else
            wait_cnt <= wait_cnt - 1'b1;
        end
        ST_DONE: begin
          bus.Ready <= 1'b1;
          bus.Fault <= req_fault;
          if (!req_fault && !req.write)
            bus.Read_Data <= load_data;
          state <= ST_IDLE;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl, two instances:
// zero wait states (u0) and three wait states (u3).
module tb_data_memory_ctrl;

  localparam logic [1:0] B = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] W = 2'b10;

  typedef struct {
    logic [31:0] rd;
    logic        f;
  } exp_t;

  logic clk = 1'b0;
  logic rst0, rst3;

  logic        mr[2];
  logic        mw[2];
  logic [31:0] ad[2];
  logic [31:0] wd[2];
  logic [1:0]  sz[2];
  logic        un[2];
  logic [31:0] rdd[2];
  logic        rdy[2];
  logic        flt[2];
  logic        bsy[2];

  exp_t q0[$];
  exp_t q3[$];
  exp_t e0, e3;

  int errors = 0;
  int checks = 0;
  int nrdy3 = 0;

  data_memory_ctrl_if bus0 ();
  data_memory_ctrl_if bus3 ();

  assign bus0.MemRead    = mr[0];
  assign bus0.MemWrite   = mw[0];
  assign bus0.Address    = ad[0];
  assign bus0.Write_Data = wd[0];
  assign bus0.Size       = sz[0];
  assign bus0.Unsigned   = un[0];
  assign rdd[0] = bus0.Read_Data;
  assign rdy[0] = bus0.Ready;
  assign flt[0] = bus0.Fault;
  assign bsy[0] = bus0.Busy;

  assign bus3.MemRead    = mr[1];
  assign bus3.MemWrite   = mw[1];
  assign bus3.Address    = ad[1];
  assign bus3.Write_Data = wd[1];
  assign bus3.Size       = sz[1];
  assign bus3.Unsigned   = un[1];
  assign rdd[1] = bus3.Read_Data;
  assign rdy[1] = bus3.Ready;
  assign flt[1] = bus3.Fault;
  assign bsy[1] = bus3.Busy;

  data_memory_ctrl #(.DEPTH_WORDS(16), .WAIT_STATES(0)) u0 (
    .clk (clk),
    .rst (rst0),
    .bus (bus0)
  );

  data_memory_ctrl #(.DEPTH_WORDS(16), .WAIT_STATES(3)) u3 (
    .clk (clk),
    .rst (rst3),
    .bus (bus3)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor for u0
  always @(negedge clk) begin
    if (rdy[0] === 1'b1) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL u0_unexpected_ready: got 1 expected 0");
      end else begin
        e0 = q0.pop_front();
        chk("u0_read_data", rdd[0], e0.rd);
        chk("u0_fault", {31'd0, flt[0]}, {31'd0, e0.f});
      end
    end
  end

  // Monitor for u3
  always @(negedge clk) begin
    if (rdy[1] === 1'b1) begin
      nrdy3++;
      if (q3.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL u3_unexpected_ready: got 1 expected 0");
      end else begin
        e3 = q3.pop_front();
        chk("u3_read_data", rdd[1], e3.rd);
        chk("u3_fault", {31'd0, flt[1]}, {31'd0, e3.f});
      end
    end
  end

  task automatic push(input int d, input logic [31:0] rd,
                      input logic f);
    exp_t e;
    e.rd = rd;
    e.f  = f;
    if (d == 0) q0.push_back(e);
    else        q3.push_back(e);
  endtask

  task automatic wait_idle(input int d);
    int k;
    k = 0;
    @(negedge clk);
    while (bsy[d] && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (bsy[d]) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout_%0d: got busy expected idle", d);
    end
  endtask

  task automatic issue(input int d, input logic r,
                       input logic w, input logic [31:0] a,
                       input logic [31:0] wdat,
                       input logic [1:0] s, input logic u,
                       input logic [31:0] erd,
                       input logic ef);
    int k;
    wait_idle(d);
    push(d, erd, ef);
    @(negedge clk);
    mr[d] = r;
    mw[d] = w;
    ad[d] = a;
    wd[d] = wdat;
    sz[d] = s;
    un[d] = u;
    @(posedge clk);
    #1;
    mr[d] = 1'b0;
    mw[d] = 1'b0;
    ad[d] = 32'hFFFF_FFFF;
    wd[d] = 32'h5A5A_5A5A;
    sz[d] = 2'b11;
    un[d] = ~u;
    k = 0;
    while (!rdy[d] && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk($sformatf("latency_%0d", d), 32'(k),
        (d == 0) ? 32'd1 : 32'd4);
  endtask

  initial begin
    int cnt;
    int n;
    int t[3];
    int snap;

    rst0 = 1'b1;
    rst3 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mr[i] = 1'b0;
      mw[i] = 1'b0;
      ad[i] = 32'd0;
      wd[i] = 32'd0;
      sz[i] = W;
      un[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_read_data", rdd[i], 32'd0);
      chk("rst_ready", {31'd0, rdy[i]}, 32'd0);
      chk("rst_fault", {31'd0, flt[i]}, 32'd0);
      chk("rst_busy", {31'd0, bsy[i]}, 32'd1);
    end
    rst0 = 1'b0;
    rst3 = 1'b0;

    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (bsy[0] && cnt < 100);
    chk("init_busy_cycles", 32'(cnt), 32'd16);

    issue(0, 1, 0, 32'h3C, 0, W, 0, 32'h0000_0000, 0);
    issue(0, 0, 1, 32'h08, 32'h80FF_7F01, W, 0, 32'h0, 0);
    issue(0, 1, 0, 32'h09, 0, B, 1, 32'h0000_007F, 0);
    issue(0, 1, 0, 32'h0B, 0, B, 0, 32'hFFFF_FF80, 0);
    issue(0, 1, 0, 32'h0A, 0, H, 0, 32'hFFFF_80FF, 0);
    issue(0, 1, 0, 32'h08, 0, H, 1, 32'h0000_7F01, 0);

    issue(0, 0, 1, 32'h04, 32'h1122_3344, W, 0,
          32'h0000_7F01, 0);
    issue(0, 0, 1, 32'h05, 32'hFFFF_FFAB, B, 0,
          32'h0000_7F01, 0);
    issue(0, 1, 0, 32'h04, 0, W, 0, 32'h1122_AB44, 0);
    issue(0, 0, 1, 32'h06, 32'h1234_BEEF, H, 0,
          32'h1122_AB44, 0);
    issue(0, 1, 0, 32'h04, 0, W, 1, 32'hBEEF_AB44, 0);

    issue(0, 1, 0, 32'h02, 0, W, 0, 32'hBEEF_AB44, 1);
    issue(0, 0, 1, 32'h01, 32'h0000_FFFF, H, 0,
          32'hBEEF_AB44, 1);
    issue(0, 1, 0, 32'h04, 0, 2'b11, 0, 32'hBEEF_AB44, 1);
    issue(0, 1, 0, 32'h40, 0, W, 0, 32'hBEEF_AB44, 1);
    issue(0, 0, 1, 32'h40, 32'h1, W, 0, 32'hBEEF_AB44, 1);
    issue(0, 1, 1, 32'h04, 32'h0, W, 0, 32'hBEEF_AB44, 1);
    issue(0, 1, 0, 32'h00, 0, W, 0, 32'h0000_0000, 0);
    issue(0, 1, 0, 32'h04, 0, W, 0, 32'hBEEF_AB44, 0);

    wait_idle(1);
    issue(1, 0, 1, 32'h0C, 32'h1234_5678, W, 0, 32'h0, 0);
    issue(1, 1, 0, 32'h0E, 0, H, 0, 32'h0000_1234, 0);
    issue(1, 1, 0, 32'h0C, 0, W, 0, 32'h1234_5678, 0);

    wait_idle(1);
    push(1, 32'h1234_5678, 0);
    push(1, 32'h1234_5678, 0);
    push(1, 32'h1234_5678, 0);
    @(negedge clk);
    mr[1] = 1'b1;
    ad[1] = 32'h0C;
    sz[1] = W;
    n = 0;
    cnt = 0;
    while (n < 3 && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
      if (rdy[1]) begin
        t[n] = cnt;
        n++;
      end else if (n == 0) begin
        chk("ws3_busy_before_ready", {31'd0, bsy[1]}, 32'd1);
      end
    end
    mr[1] = 1'b0;
    chk("b2b_ready_count", 32'(n), 32'd3);
    if (n == 3) begin
      chk("b2b_first", 32'(t[0]), 32'd5);
      chk("b2b_gap1", 32'(t[1] - t[0]), 32'd5);
      chk("b2b_gap2", 32'(t[2] - t[1]), 32'd5);
    end

    wait_idle(1);
    @(negedge clk);
    snap = nrdy3;
    @(negedge clk);
    mw[1] = 1'b1;
    ad[1] = 32'h0;
    wd[1] = 32'hDEAD_BEEF;
    sz[1] = W;
    @(posedge clk);
    #1;
    mw[1] = 1'b0;
    @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    wait_idle(1);
    repeat (3) @(negedge clk);
    chk("midrst_no_ready", 32'(nrdy3), 32'(snap));
    issue(1, 1, 0, 32'h00, 0, W, 0, 32'h0000_0000, 0);
    issue(1, 1, 0, 32'h0C, 0, W, 0, 32'h0000_0000, 0);

    repeat (8) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q3_drained", 32'(q3.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Parametrised, clocked data memory for the MIPS datapath, replacing the word-indexed combinational data memory on the load/store path. Adds byte addressing, byte/halfword/word access with sign or zero extension, configurable wait states behind a request/ready handshake, fault reporting and a sequential zero-fill after reset. Sits between the EX-stage address/store-data outputs and the WB-stage load-data mux. The stall logic holds the pipeline while `Busy` is high.

## Interface
- `DEPTH_WORDS`, default 256. Number of 32-bit words; power of two, at least 4.
- `WAIT_STATES`, default 0. Extra cycles inserted between request acceptance and completion; range 0–7.
- `clk`  in  1  Single clock. All state changes on the rising edge.
- `rst`  in  1  Synchronous, active-high reset.
- `MemRead`  in  1  Load request, sampled only in IDLE.
- `MemWrite`  in  1  Store request, sampled only in IDLE.
- `Address`  in  32  Byte address.
- `Write_Data`  in  32  Store data, right-justified for byte and halfword accesses.
- `Size`  in  2  Access size: 00 byte, 01 halfword, 10 word, 11 reserved.
- `Unsigned`  in  1  Loads only. 1 zero-extends, 0 sign-extends.
- `Read_Data`  out  32  Extended load result.
- `Ready`  out  1  One-cycle completion pulse.
- `Fault`  out  1  One-cycle pulse, coincident with `Ready`, when an access is rejected.
- `Busy`  out  1  High during INIT and while a request is in flight.

## Operation
- The FSM has four states: INIT, IDLE, WAIT, DONE.
- **INIT**
  - Entered on `rst`.
  - A counter writes 0 to word 0 through word DEPTH_WORDS-1, one word per cycle.
  - Goes to IDLE after the last word is written.
  - Requests are ignored in this state; they are not queued.
- **IDLE**
  - When exactly one of `MemRead` or `MemWrite` is high, latch `Address`, `Write_Data`, `Size`, `Unsigned` and the direction.
  - If WAIT_STATES > 0, go to WAIT and load the wait counter with WAIT_STATES-1. Otherwise go to DONE.
  - If both request inputs are high, latch the request as faulted and proceed with the same timing.
- **WAIT**: count down the wait counter; go to DONE when it reaches 0.
- **DONE**
  - Perform the access, pulse `Ready` (and `Fault` if applicable), return to IDLE.
  - A request held high continuously is accepted again on the cycle after DONE.
- **Fault conditions**, checked on the latched request:
  - `Size` = 11.
  - Halfword access with `Address[0]` = 1.
  - Word access with `Address[1:0]` ≠ 00.
  - Word index `Address[31:2]` ≥ DEPTH_WORDS.
  - Both `MemRead` and `MemWrite` high.
- **On a fault**: memory is unchanged and `Read_Data` keeps its previous value.
- **Lane mapping** is little-endian. The byte at `Address[1:0]`=k occupies bits 8k+7:8k; the halfword at `Address[1]`=h occupies bits 16h+15:16h.
- **Stores**: read-modify-write of the addressed word. Only the addressed lanes change.
- **Loads**: extract the addressed lane and extend to 32 bits according to `Unsigned`. Word loads ignore `Unsigned`.

## Timing
- **Reset values**: `Read_Data`=0, `Ready`=0, `Fault`=0, `Busy`=1. State = INIT, INIT counter = 0.
- **Reset mid-operation**:
  - `rst` has priority over every state.
  - An in-flight store whose DONE has not yet been reached is discarded.
  - INIT restarts from word 0.
- `Busy` falls on the cycle INIT → IDLE, DEPTH_WORDS cycles after `rst` deasserts.
- **Latency**: a request sampled in IDLE at edge n produces `Ready` during cycle n+1+WAIT_STATES.
- `Read_Data` is registered and valid in the same cycle as `Ready`. It holds until the next successful load completes.
- A store is visible to a load accepted on any later cycle (no bypass hazard).
- Inputs may change freely after the acceptance edge.
- `Busy` is high from the acceptance edge through the `Ready` cycle and low in IDLE.

## Structure
- **Package `data_mem_pkg`**:
  - Size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`.
  - FSM state enum (INIT, IDLE, WAIT, DONE).
  - Function computing the fault condition.
- **Sub-module `mem_lane_align`**: combinational.
  - Store path: merges a store into an old word given `Size` and `Address[1:0]`.
  - Load path: extracts and extends load data.
  - Instantiated once.
- The storage array, FSM and counters live in `data_memory_ctrl`.

## Test plan
- **Reset and INIT**, DEPTH_WORDS=16: pulse `rst` → `Busy` stays high for exactly 16 cycles. Then a load of word 0x3C returns 0x00000000.
- **Store then loads**, WAIT_STATES=0:
  - Store word 0x80FF7F01 to 0x8.
  - Load byte unsigned at 0x9 → 0x0000007F.
  - Load byte signed at 0xB → 0xFFFFFF80.
  - Load half signed at 0xA → 0xFFFF80FF.
- **Partial stores**: store byte 0xAB to 0x5 over word 0x11223344 → word load at 0x4 returns 0x1122AB44. Then store half 0xBEEF to 0x6 → returns 0xBEEFAB44.
- **Wait states**, WAIT_STATES=3: request at edge n → `Ready` in cycle n+4 only, `Busy` high from n to n+4. Back-to-back held `MemRead` gives `Ready` every 5 cycles.
- **Faults**, each giving `Fault`=`Ready`=1 with memory and `Read_Data` unchanged:
  - Word load at 0x2.
  - Half store at 0x1.
  - `Size`=11.
  - Address 4×DEPTH_WORDS.
  - `MemRead`=`MemWrite`=1.
- **Reset mid-store**, WAIT_STATES=3: assert `rst` during WAIT of a store of 0xDEADBEEF to 0x0 → after INIT, word 0 reads 0x00000000 and no `Ready` is seen.
